// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stage stall requests and exception info in, stall vector and redirect out.
// The core side drives through master; the sequencer consumes through slave.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    input  stall, flush, new_pc
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excepttype, cp0_epc,
    output stall, flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Six-stage pipeline sequencer: stall arbitration, exception flush FSM, stall watchdog and counter.
// stall/flush/new_pc are zero-latency from state and inputs; a flush overrides every stall request.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE   = 32'h0000_000e,
  parameter int unsigned RECOVER_CYC = 2,
  parameter int unsigned WDOG_LIMIT  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pipe_ctrl_if.slave  io_pipe,
  output logic        o_in_recover,
  output logic        o_wdog_trip,
  output logic [31:0] o_stall_count
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam int WD_W  = $clog2(WDOG_LIMIT + 1);

  logic [1:0]       r_state;
  logic [REC_W-1:0] r_rec_cnt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_wdog_trip;
  logic [31:0]      r_stall_count;

  logic             w_exc_take;
  logic [5:0]       w_stall_req;
  logic [5:0]       w_stall;
  logic             w_stall0;

  // Deeper stalls freeze every stage upstream of the requester.
  always_comb begin
    w_stall_req = 6'b000000;
    if (io_pipe.stallreq_mem)
      w_stall_req = 6'b011111;
    else if (io_pipe.stallreq_ex)
      w_stall_req = 6'b001111;
    else if (io_pipe.stallreq_id)
      w_stall_req = 6'b000111;
  end

  // State gate first so an unknown excepttype outside RUN resolves to no flush.
  assign w_exc_take = !i_rst && (r_state == S_RUN) && (io_pipe.excepttype != 32'h0);
  assign w_stall    = (i_rst || w_exc_take || (r_state == S_FLUSH)) ? 6'b000000 : w_stall_req;
  assign w_stall0   = w_stall[0];

  assign io_pipe.stall  = w_stall;
  assign io_pipe.flush  = w_exc_take;
  assign io_pipe.new_pc = !w_exc_take ? 32'h0 :
                          (io_pipe.excepttype == ERET_CODE) ? io_pipe.cp0_epc : EXC_VECTOR;

  assign o_in_recover  = !i_rst && (r_state == S_RECOVER);
  assign o_wdog_trip   = r_wdog_trip;
  assign o_stall_count = r_stall_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_RUN;
      r_rec_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_exc_take)
            r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (RECOVER_CYC == 0) begin
            r_state <= S_RUN;
          end else begin
            r_state   <= S_RECOVER;
            r_rec_cnt <= REC_W'(RECOVER_CYC - 1);
          end
        end
        S_RECOVER: begin
          if (r_rec_cnt == '0)
            r_state <= S_RUN;
          else
            r_rec_cnt <= r_rec_cnt - 1'b1;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Watchdog counts consecutive PC stalls; a flush forces stall[0]=0 and so also clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd_cnt      <= '0;
      r_wdog_trip   <= 1'b0;
      r_stall_count <= 32'h0;
    end else begin
      if (!w_stall0)
        r_wd_cnt <= '0;
      else if (r_wd_cnt != WD_W'(WDOG_LIMIT))
        r_wd_cnt <= r_wd_cnt + 1'b1;

      if (w_stall0 && (r_wd_cnt >= WD_W'(WDOG_LIMIT - 1)))
        r_wdog_trip <= 1'b1;

      if (w_stall0)
        r_stall_count <= r_stall_count + 32'h1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus watchdog and reset sequences.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        in_recover;
  logic        wdog_trip;
  logic [31:0] stall_count;

  int n_cmp;
  int n_err;

  pipe_ctrl_if u_if ();

  pipe_ctrl #(
    .EXC_VECTOR  (32'h0000_0020),
    .ERET_CODE   (32'h0000_000e),
    .RECOVER_CYC (2),
    .WDOG_LIMIT  (8)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .io_pipe       (u_if),
    .o_in_recover  (in_recover),
    .o_wdog_trip   (wdog_trip),
    .o_stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        id;
    logic        ex;
    logic        mem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        rec;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                       input logic [31:0] exc, input logic [31:0] epc);
    rst                = r;
    u_if.stallreq_id   = id;
    u_if.stallreq_ex   = ex;
    u_if.stallreq_mem  = mem;
    u_if.excepttype    = exc;
    u_if.cp0_epc       = epc;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h5, 32'hffff);

    //        rst   id    ex    mem   exc         epc           stall      flush pc            rec   cnt
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h5,      32'hffff,     6'b000000, 1'b0, 32'h0,        1'b0, 32'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h5,      32'hffff,     6'b000000, 1'b0, 32'h0,        1'b0, 32'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000111, 1'b0, 32'h0,        1'b0, 32'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,      32'h0,        6'b001111, 1'b0, 32'h0,        1'b0, 32'd1};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      32'h0,        6'b011111, 1'b0, 32'h0,        1'b0, 32'd2};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0,      32'h0,        6'b011111, 1'b0, 32'h0,        1'b0, 32'd3};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd4};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h8,      32'h0,        6'b000000, 1'b1, 32'h20,       1'b0, 32'd4};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd4};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b1, 32'd4};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1,      32'h0,        6'b000111, 1'b0, 32'h0,        1'b1, 32'd4};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1,      32'h0,        6'b000000, 1'b1, 32'h20,       1'b0, 32'd5};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd5};
    vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hxxxxxxxx, 32'h0,      6'b000000, 1'b0, 32'h0,        1'b1, 32'd5};
    vt[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b1, 32'd5};
    vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'he,      32'h1234,     6'b000000, 1'b1, 32'h1234,     1'b0, 32'd5};
    vt[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd5};
    vt[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h3,      32'h0,        6'b000000, 1'b1, 32'h20,       1'b0, 32'd0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd0};
    vt[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b1, 32'd0};
    vt[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b1, 32'd0};
    vt[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      32'h0,        6'b000000, 1'b0, 32'h0,        1'b0, 32'd0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].id, vt[i].ex, vt[i].mem, vt[i].exc, vt[i].epc);
      #2;
      chk($sformatf("row%0d stall", i),  {26'h0, u_if.stall},  {26'h0, vt[i].stall});
      chk($sformatf("row%0d flush", i),  {31'h0, u_if.flush},  {31'h0, vt[i].flush});
      chk($sformatf("row%0d new_pc", i), u_if.new_pc,          vt[i].pc);
      chk($sformatf("row%0d recover", i), {31'h0, in_recover}, {31'h0, vt[i].rec});
      chk($sformatf("row%0d count", i),  stall_count,          vt[i].cnt);
      chk($sformatf("row%0d wdog", i),   {31'h0, wdog_trip},   32'h0);
    end

    // Watchdog: two 7-cycle stall runs separated by a release must not trip.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (7) @(negedge clk);
    chk("wdog 7a", {31'h0, wdog_trip}, 32'h0);
    u_if.stallreq_ex = 1'b0;
    @(negedge clk);
    u_if.stallreq_ex = 1'b1;
    repeat (7) @(negedge clk);
    chk("wdog 7b", {31'h0, wdog_trip}, 32'h0);
    u_if.stallreq_ex = 1'b0;
    @(negedge clk);
    chk("wdog released", {31'h0, wdog_trip}, 32'h0);

    // Eight consecutive stall cycles trip it on the 8th edge, and it stays set.
    u_if.stallreq_ex = 1'b1;
    repeat (7) @(negedge clk);
    chk("wdog 8 at 7", {31'h0, wdog_trip}, 32'h0);
    @(negedge clk);
    chk("wdog 8 at 8", {31'h0, wdog_trip}, 32'h1);
    u_if.stallreq_ex = 1'b0;
    repeat (3) @(negedge clk);
    chk("wdog sticky", {31'h0, wdog_trip}, 32'h1);
    chk("stall_count 22", stall_count, 32'd22);

    rst = 1'b1;
    @(negedge clk);
    chk("wdog reset", {31'h0, wdog_trip}, 32'h0);
    chk("count reset", stall_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
